// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a small valid/ready FIFO, framing-error pulse and sticky overflow.
// Define UART_RX_MONITOR_DISPLAY_EN to echo received bytes and frame errors in simulation.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam int            DEPTH   = 2 ** FIFO_AW;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // Two-flop synchronizer; both stages reset to the idle-high line level.
  logic rx_p0_q, rx_p1_q;
  logic rx_s;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rx_p0_q <= 1'b1;
      rx_p1_q <= 1'b1;
    end else begin
      rx_p0_q <= rx_i;
      rx_p1_q <= rx_p0_q;
    end
  end

  assign rx_s = rx_p1_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    sh_q;
  logic          sample;
  logic          push;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    sample      = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit so short low glitches are ignored.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d  = '0;
          sample = 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) yields only the single error already flagged.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Data path registers carry no reset; only control state is reset.
  always_ff @(posedge wb_clk_i) begin
    if (sample) sh_q <= {rx_s, sh_q[7:1]};
  end

  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];
  logic             overflow_q, overflow_d;
  logic             empty, full, pop, push_ok, drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop     = !empty && ready_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | drop;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= sh_q;
  end

`ifdef UART_RX_MONITOR_DISPLAY_EN
  always_ff @(posedge wb_clk_i) begin
    if (push_ok)     $write("%c", sh_q);
    if (frame_err_d) $display("uart_rx_monitor: frame error at %0t", $time);
  end
`else
`endif

  assign data_o      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign valid_o     = !empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at CLKS_PER_BIT=16, FIFO_AW=2.
`timescale 1ns/1ps
module tb_uart_rx_monitor;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overflow_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_monitor #(.CLKS_PER_BIT(C), .FIFO_AW(2)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  // Called just after a rising edge; the falling start edge sits right after edge 0.
  task automatic uart_send(input logic [7:0] b, input int stop_cycles, input logic stop_val);
    rx_i = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx_i = stop_val;
    repeat (stop_cycles) @(posedge clk);
    #1;
    rx_i = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Cycle n is the one following rising edge n after the call.
  task automatic watch(input int cycles, output int first, output logic [7:0] d,
                       output int vcnt, output int ferr, output int bcnt);
    first = -1; d = 8'h00; vcnt = 0; ferr = 0; bcnt = 0;
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_o === 1'b1) begin
        if (first < 0) begin
          first = n;
          d = data_o;
        end
        vcnt++;
      end
      if (frame_err_o === 1'b1) ferr++;
      if (busy_o === 1'b1) bcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
  endtask

  // 2 sync + 1 detect + 152 frame cycles: valid_o is seen after edge 155 and consumed on edge 156.
  task automatic test_single_byte;
    int first, vcnt, ferr, bcnt;
    logic [7:0] d;
    ready_i = 1'b1;
    fork
      uart_send(8'h55, C, 1'b1);
      watch(200, first, d, vcnt, ferr, bcnt);
    join
    n_cmp++; if (first !== 155) begin n_err++; $display("FAIL byte55_latency: got %0d want 155", first); end
    n_cmp++; if (d !== 8'h55) begin n_err++; $display("FAIL byte55_data: got %h want 55", d); end
    n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL byte55_valid_len: got %0d want 1", vcnt); end
    n_cmp++; if (ferr !== 0) begin n_err++; $display("FAIL byte55_ferr: got %0d want 0", ferr); end
    idle(C);
  endtask

  task automatic test_glitch;
    int first, vcnt, ferr, bcnt;
    logic [7:0] d;
    ready_i = 1'b1;
    fork
      begin
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_i = 1'b1;
      end
      watch(40, first, d, vcnt, ferr, bcnt);
    join
    n_cmp++; if (bcnt !== 8) begin n_err++; $display("FAIL glitch_busy_len: got %0d want 8", bcnt); end
    n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL glitch_push: got %0d want 0", vcnt); end
    n_cmp++; if (ferr !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", ferr); end
    idle(C);
  endtask

  // Stop held low 40 cycles (line high again at cycle 184); next frame falls at cycle 188.
  task automatic test_frame_error;
    int first, vcnt, ferr, bcnt;
    logic [7:0] d;
    ready_i = 1'b1;
    fork
      begin
        uart_send(8'hA3, 40, 1'b0);
        idle(4);
        uart_send(8'h3C, C, 1'b1);
      end
      watch(450, first, d, vcnt, ferr, bcnt);
    join
    n_cmp++; if (ferr !== 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", ferr); end
    n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL ferr_pushes: got %0d want 1", vcnt); end
    n_cmp++; if (d !== 8'h3C) begin n_err++; $display("FAIL ferr_next_data: got %h want 3c", d); end
    n_cmp++; if (first !== 343) begin n_err++; $display("FAIL ferr_next_latency: got %0d want 343", first); end
    idle(C);
  endtask

  task automatic test_overflow;
    ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      uart_send(8'(b), C, 1'b1);
      idle(C);
    end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow_o); end
    uart_send(8'h05, C, 1'b1);
    idle(C);
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
    ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'(k)) begin
        n_err++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", k, valid_o, data_o, 8'(k));
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", valid_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
    ready_i = 1'b0;
    idle(2);
  endtask

  // Bit 4 of 0xF0 spans cycles 80..95; reset lands at cycle 85.
  task automatic test_reset_mid_frame;
    int first, vcnt, ferr, bcnt;
    logic [7:0] d;
    ready_i = 1'b0;
    uart_send(8'h11, C, 1'b1);
    idle(C);
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", valid_o); end
    fork
      uart_send(8'hF0, C, 1'b1);
      begin
        repeat (85) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovf: got %b want 0", overflow_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_ferr: got %b want 0", frame_err_o); end
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(C);
    n_cmp++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL rst_abandon: got v=%b busy=%b want 0/0", valid_o, busy_o);
    end
    ready_i = 1'b1;
    fork
      uart_send(8'h9E, C, 1'b1);
      watch(200, first, d, vcnt, ferr, bcnt);
    join
    n_cmp++; if (d !== 8'h9E || vcnt !== 1 || first !== 155) begin
      n_err++; $display("FAIL rst_next_byte: got d=%h n=%0d at %0d want 9e 1 155", d, vcnt, first);
    end
    ready_i = 1'b0;
    idle(C);
  endtask

  // Push of 0x77 happens on edge 155; ready_i is high only for the cycle before it.
  task automatic test_full_pop_same_cycle;
    logic [7:0] exp [4];
    exp[0] = 8'h02; exp[1] = 8'h03; exp[2] = 8'h04; exp[3] = 8'h77;
    ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      uart_send(8'(b), C, 1'b1);
      idle(C);
    end
    n_cmp++; if (valid_o !== 1'b1 || overflow_o !== 1'b0) begin
      n_err++; $display("FAIL full_pre: got v=%b ovf=%b want 1/0", valid_o, overflow_o);
    end
    fork
      uart_send(8'h77, C, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
      end
    join
    idle(C);
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL full_pop_ovf: got %b want 0", overflow_o); end
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (valid_o !== 1'b1 || data_o !== exp[k]) begin
        n_err++; $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h", k, valid_o, data_o, exp[k]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", valid_o); end
    ready_i = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_glitch;
    test_frame_error;
    test_overflow;
    test_reset_mid_frame;
    test_full_pop_same_cycle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded 1 ms without completing");
    $fatal(1, "timeout");
  end

endmodule
